// File: rtl/mips_controller.sv
// Multicycle control FSM for a byte-fetch MIPS subset (lb, sb, R-type, beq, j, addi).
// Define BNE_SUPPORT_EN to add the optional bne instruction via state BNEEX.
module mips_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       memwrite,
  output logic [3:0] irwrite,
  output logic       pcen,
  output logic [2:0] alucont
);

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR,
    SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR
`ifdef BNE_SUPPORT_EN
    , BNEEX
`endif
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef BNE_SUPPORT_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t state, state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH1;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH1;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsource   = 2'b00;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 4'b0000;
    pcen       = 1'b0;
    alucont    = 3'b010;

    case (state)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        irwrite = 4'b0001 << state[1:0];
        alusrcb = 2'b01;
        pcen    = 1'b1;
        state_next = (state == FETCH4) ? DECODE : state_t'(state + 4'd1);
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LB, OP_SB: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_J:         state_next = JEX;
          OP_ADDI:      state_next = ADDIEX;
`ifdef BNE_SUPPORT_EN
          OP_BNE:       state_next = BNEEX;
`endif
          default:      state_next = FETCH1;
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (op == OP_LB) ? LBRD : SBWR;
      end
      LBRD: begin
        iord       = 1'b1;
        state_next = LBWR;
      end
      LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      SBWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          6'b100010: alucont = 3'b110;
          6'b100100: alucont = 3'b000;
          6'b100101: alucont = 3'b001;
          6'b101010: alucont = 3'b111;
          default:   alucont = 3'b010;
        endcase
        state_next = RTYPEWR;
      end
      RTYPEWR: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQEX: begin
        alusrca  = 1'b1;
        alucont  = 3'b110;
        pcsource = 2'b01;
        pcen     = zero;
      end
`ifdef BNE_SUPPORT_EN
      BNEEX: begin
        alusrca  = 1'b1;
        alucont  = 3'b110;
        pcsource = 2'b01;
        pcen     = ~zero;
      end
`endif
      JEX: begin
        pcsource = 2'b10;
        pcen     = 1'b1;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = ADDIWR;
      end
      ADDIWR: begin
        regwrite = 1'b1;
      end
      // Unused encodings fall back to FETCH1 with idle outputs.
      default: state_next = FETCH1;
    endcase
  end

endmodule

// File: doc/mips_controller.md
MIPS_CONTROLLER -- requirements
Module: mips_controller

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 SHALL provide ports:
  clk        in   1  rising-edge clock
  reset      in   1  asynchronous, active-high reset
  op         in   6  instr[31:26] opcode
  funct      in   6  instr[5:0] R-type function field
  zero       in   1  datapath ALU-result-zero flag
  alusrca    out  1  0=PC, 1=A register
  alusrcb    out  2  00=writedata, 01=const 1, 10=imm byte, 11=imm<<2
  pcsource   out  2  00=aluresult, 01=aluout, 10=jump target
  iord       out  1  address mux: 0=PC, 1=aluout
  memtoreg   out  1  regfile write data: 0=aluout, 1=MDR
  regdst     out  1  write address: 0=rt, 1=rd
  regwrite   out  1  regfile write enable
  memwrite   out  1  memory byte write strobe
  irwrite    out  4  one-hot instruction-byte load enable
  pcen       out  1  PC register enable
  alucont    out  3  ALU operation

Function
REQ-003 SHALL be a multicycle FSM with one state register on clk; outputs depend on the state only, except pcen (also on zero) and alucont (also on funct).
REQ-004 States: FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR; 4-bit encoding is implementation choice.
REQ-005 Any output not listed for a state SHALL be 0; alucont default 010 (add).
REQ-006 FETCHn (n=1..4): irwrite bit n-1 set, alusrca=0, alusrcb=01, pcsource=00, pcen=1; FETCH1->2->3->4->DECODE unconditionally.
REQ-007 DECODE: alusrca=0, alusrcb=11, alucont=010; next by op: 100000 lb->MEMADR, 101000 sb->MEMADR, 000000->RTYPEEX, 000100->BEQEX, 000010->JEX, 001000->ADDIEX, any other->FETCH1.
REQ-008 MEMADR: alusrca=1, alusrcb=10, add; next LBRD if op=100000, else SBWR.
REQ-009 LBRD: iord=1, next LBWR; LBWR: regwrite=1, memtoreg=1, regdst=0, next FETCH1.
REQ-010 SBWR: iord=1, memwrite=1, next FETCH1.
REQ-011 RTYPEEX: alusrca=1, alusrcb=00, alucont by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010; next RTYPEWR.
REQ-012 RTYPEWR: regwrite=1, regdst=1, memtoreg=0, next FETCH1.
REQ-013 BEQEX: alusrca=1, alusrcb=00, alucont=110, pcsource=01, pcen=zero (same-cycle), next FETCH1.
REQ-014 JEX: pcsource=10, pcen=1, next FETCH1.
REQ-015 ADDIEX: alusrca=1, alusrcb=10, add, next ADDIWR; ADDIWR: regwrite=1, regdst=0, memtoreg=0, next FETCH1.
REQ-016 Instruction latency (cycles incl. fetch): lb 8, sb 7, R-type 7, addi 7, beq 6, j 6, illegal op 5.
REQ-017 Unused state encodings SHALL transition to FETCH1 next cycle with all outputs 0 except alucont=010.
REQ-018 op/funct/zero SHALL be sampled only in the states that use them; changes elsewhere have no effect.

Reset
REQ-019 reset high SHALL force state FETCH1 asynchronously, independent of clk.
REQ-020 While reset is high, outputs equal FETCH1 values: irwrite=0001, alusrcb=01, pcen=1, alucont=010, all others 0.
REQ-021 Reset asserted mid-instruction SHALL abandon it; no regwrite/memwrite after reset assertion; first edge after release advances FETCH1->FETCH2.

Configuration
REQ-022 Macro BNE_SUPPORT_EN, when defined, SHALL add state BNEEX: DECODE with op=000101 -> BNEEX; BNEEX identical to BEQEX except pcen=~zero; next FETCH1.
REQ-023 Without BNE_SUPPORT_EN, op=000101 SHALL be illegal (DECODE->FETCH1) and BNEEX SHALL not exist.

Verification
REQ-024 Reset mid-RTYPEEX, release -> state FETCH1, outputs per REQ-020, no regwrite pulse seen.
REQ-025 op=100000 -> sequence F1..F4, DECODE, MEMADR, LBRD(iord=1), LBWR(regwrite=1, memtoreg=1), FETCH1; 8 cycles.
REQ-026 op=000000, funct=100010 -> RTYPEEX alucont=110, RTYPEWR regwrite=1, regdst=1.
REQ-027 op=000100 in BEQEX with zero=1 -> pcen=1, pcsource=01; zero=0 -> pcen=0; both return to FETCH1.
REQ-028 op=101000 -> SBWR memwrite=1 for exactly one cycle, regwrite never 1; op=111111 -> DECODE->FETCH1, no write strobes.
REQ-029 With BNE_SUPPORT_EN, op=000101, zero=0 -> BNEEX pcen=1; without macro -> DECODE->FETCH1.
